// File: rtl/picorv32_mem_responder_if.sv
// Native picorv32 memory bus between the core (master) and the
// latency-bounded memory responder (slave). Also carries the per-request
// wait-state count and the responder's status flags.
interface picorv32_mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [3:0]  wait_cycles;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        proto_err;
    logic        oob_err;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, wait_cycles,
        input  mem_ready, mem_rdata, busy, proto_err, oob_err
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, wait_cycles,
        output mem_ready, mem_rdata, busy, proto_err, oob_err
    );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Memory-side responder for the picorv32 native interface: accepts a request,
// inserts min(wait_cycles, MAX_WAIT) wait states, then returns a one-cycle
// mem_ready pulse with read data, or commits a byte-strobed write. Sticky
// flags report core protocol violations and misaligned/out-of-range accesses.
module picorv32_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int MAX_WAIT  = 4,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                        clk,
    input  logic                        resetn,
    picorv32_mem_responder_if.slave     bus
);
    localparam int          DEPTH     = 1 << ADDR_BITS;
    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0 : 32'hx;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        unused_instr_q, unused_instr_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        proto_q, proto_d;
    logic        oob_q, oob_d;

    // Array is never reset; only its time-0 content is selectable.
    logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};

    logic [31:0] acc_addr;
    logic [3:0]  acc_wstrb;
    logic [3:0]  wait_eff;
    logic [31:0] wmerge;

    // Misaligned, or any address bit above the array's byte range set.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_BITS + 2)) != 32'h0);
    endfunction

    // Next-state, latching, flag and registered-output computation.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        unused_instr_d = unused_instr_q;
        proto_d        = proto_q;
        oob_d          = oob_q;
        ready_d        = 1'b0;
        rdata_d        = 32'h0;
        wait_eff       = (bus.wait_cycles > 4'(MAX_WAIT)) ? 4'(MAX_WAIT) : bus.wait_cycles;
        // The transaction being decided: live bus in IDLE, latched copy after.
        acc_addr       = addr_q;
        acc_wstrb      = wstrb_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    addr_d         = bus.mem_addr;
                    wdata_d        = bus.mem_wdata;
                    wstrb_d        = bus.mem_wstrb;
                    unused_instr_d = bus.mem_instr;
                    acc_addr       = bus.mem_addr;
                    acc_wstrb      = bus.mem_wstrb;
                    cnt_d          = wait_eff;
                    state_d        = (wait_eff != 4'd0) ? S_WAIT : S_RESP;
                    if (addr_bad(bus.mem_addr))
                        oob_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = S_RESP;
            end
            S_RESP: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The core must hold a stable request until it sees mem_ready.
        if (state_q != S_IDLE) begin
            if (!bus.mem_valid || bus.mem_addr != addr_q || bus.mem_wstrb != wstrb_q ||
                (wstrb_q != 4'h0 && bus.mem_wdata != wdata_q))
                proto_d = 1'b1;
        end

        // Response data is registered on the edge that enters RESP.
        if (state_d == S_RESP && state_q != S_RESP) begin
            ready_d = 1'b1;
            if (acc_wstrb == 4'h0 && !addr_bad(acc_addr))
                rdata_d = mem_q[acc_addr[ADDR_BITS+1:2]];
        end

        // Byte-lane merge of the latched write into the addressed word.
        wmerge = mem_q[addr_q[ADDR_BITS+1:2]];
        if (wstrb_q[0]) wmerge[7:0]   = wdata_q[7:0];
        if (wstrb_q[1]) wmerge[15:8]  = wdata_q[15:8];
        if (wstrb_q[2]) wmerge[23:16] = wdata_q[23:16];
        if (wstrb_q[3]) wmerge[31:24] = wdata_q[31:24];
    end

    // Control state, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            wstrb_q        <= 4'h0;
            unused_instr_q <= 1'b0;
            ready_q        <= 1'b0;
            rdata_q        <= 32'h0;
            proto_q        <= 1'b0;
            oob_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            unused_instr_q <= unused_instr_d;
            ready_q        <= ready_d;
            rdata_q        <= rdata_d;
            proto_q        <= proto_d;
            oob_q          <= oob_d;
        end
    end

    // Write commits at the edge ending RESP; a reset on that edge abandons it.
    always_ff @(posedge clk) begin
        if (resetn && state_q == S_RESP && wstrb_q != 4'h0 && !addr_bad(addr_q))
            mem_q[addr_q[ADDR_BITS+1:2]] <= wmerge;
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.proto_err = proto_q;
    assign bus.oob_err   = oob_q;
endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Bench for picorv32_mem_responder: directed vector table, hand-written
// protocol/reset corner sequences, then random traffic against a byte-level
// memory model with the latency rule N = min(wait, MAX_WAIT).
module tb_picorv32_mem_responder;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    picorv32_mem_responder_if bus();

    picorv32_mem_responder #(
        .ADDR_BITS(10),
        .MAX_WAIT (4),
        .INIT_ZERO(1'b1)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  wt;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_oob;
    } vec_t;

    int nchk  = 0;
    int npass = 0;

    // Byte-addressed reference memory: 4 KiB, little-endian words.
    byte unsigned mbytes [4096];
    logic         model_oob = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic model_access(input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, output logic [31:0] rd);
        rd = 32'h0;
        if (a % 4 != 0 || a >= 4096) model_oob = 1'b1;
        else if (ws == 4'h0) rd = {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]};
        else for (int i = 0; i < 4; i++) if (ws[i]) mbytes[a+i] = wd[8*i +: 8];
    endtask

    task automatic reset_dut();
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_oob = 1'b0;
    endtask

    // Caller is at a negedge with the DUT idle; returns at a negedge with valid low.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [3:0] wt, output logic [31:0] rd, output int lat);
        bus.mem_valid   = 1'b1;
        bus.mem_instr   = 1'($urandom_range(0, 1));
        bus.mem_addr    = a;
        bus.mem_wdata   = wd;
        bus.mem_wstrb   = ws;
        bus.wait_cycles = wt;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.wait_cycles = 4'($urandom_range(0, 15));
        end while (!bus.mem_ready && lat < 30);
        rd = bus.mem_rdata;
        check("busy_in_resp", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("ready_single_pulse", 32'(bus.mem_ready), 32'd0);
        check("rdata_zero_outside_resp", bus.mem_rdata, 32'h0);
        check("busy_idle_after", 32'(bus.busy), 32'd0);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    // Request read 0x100 with 3 wait states and disturb it during WAIT.
    task automatic glitch_seq(input bit drop_valid);
        int lat;
        reset_dut();
        bus.mem_valid   = 1'b1;
        bus.mem_addr    = 32'h100;
        bus.mem_wdata   = 32'h0;
        bus.mem_wstrb   = 4'h0;
        bus.wait_cycles = 4'd3;
        @(posedge clk);
        @(negedge clk);
        check("proto_clean_before", 32'(bus.proto_err), 32'd0);
        if (drop_valid) bus.mem_valid = 1'b0;
        else bus.mem_addr = 32'h0;
        @(negedge clk);
        if (drop_valid) check("proto_valid_drop", 32'(bus.proto_err), 32'd1);
        else check("proto_addr_change", 32'(bus.proto_err), 32'd1);
        lat = 2;
        while (!bus.mem_ready && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("glitch_latency", 32'(lat), 32'd4);
        check("glitch_rdata_latched", bus.mem_rdata, 32'hDEAD33EF);
        @(posedge clk);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        check("proto_sticky", 32'(bus.proto_err), 32'd1);
        reset_dut();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [10];
        logic [31:0] rd, exp_rd, a, wd;
        logic [3:0]  ws, wt;
        int          lat, exp_lat;

        bus.mem_valid   = 1'b0;
        bus.mem_instr   = 1'b0;
        bus.mem_addr    = 32'h0;
        bus.mem_wdata   = 32'h0;
        bus.mem_wstrb   = 4'h0;
        bus.wait_cycles = 4'd0;
        for (int i = 0; i < 4096; i++) mbytes[i] = 8'h00;

        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(bus.mem_ready), 32'd0);
        check("reset_rdata", bus.mem_rdata, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_proto", 32'(bus.proto_err), 32'd0);
        check("reset_oob", 32'(bus.oob_err), 32'd0);
        resetn = 1'b1;

        //          addr          wdata         wstrb wt     exp_rdata     lat oob
        vecs[0] = '{32'h0000_0000, 32'h0,         4'h0, 4'd0,  32'h0,        1, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'hDEADBEEF,  4'hF, 4'd2,  32'h0,        3, 1'b0};
        vecs[2] = '{32'h0000_0100, 32'h11223344,  4'h2, 4'd0,  32'h0,        1, 1'b0};
        vecs[3] = '{32'h0000_0100, 32'h0,         4'h0, 4'd1,  32'hDEAD33EF, 2, 1'b0};
        vecs[4] = '{32'h0000_0104, 32'h0,         4'h0, 4'd15, 32'h0,        5, 1'b0};
        vecs[5] = '{32'h0000_0100, 32'h0,         4'h0, 4'd3,  32'hDEAD33EF, 4, 1'b0};
        vecs[6] = '{32'h0000_0102, 32'h0,         4'h0, 4'd0,  32'h0,        1, 1'b1};
        vecs[7] = '{32'h0000_1100, 32'hFFFFFFFF,  4'hF, 4'd2,  32'h0,        3, 1'b1};
        vecs[8] = '{32'h0000_1000, 32'h0,         4'h0, 4'd0,  32'h0,        1, 1'b1};
        vecs[9] = '{32'h0000_0100, 32'h0,         4'h0, 4'd0,  32'hDEAD33EF, 1, 1'b1};

        for (int v = 0; v < 10; v++) begin
            do_txn(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, vecs[v].wt, rd, lat);
            model_access(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, exp_rd);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            if (vecs[v].wstrb == 4'h0)
                check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            check($sformatf("vec%0d_oob", v), 32'(bus.oob_err), 32'(vecs[v].exp_oob));
            check($sformatf("vec%0d_proto", v), 32'(bus.proto_err), 32'd0);
        end

        glitch_seq(1'b0);
        glitch_seq(1'b1);

        // Reset lands in the RESP cycle of a write: nothing is committed.
        bus.mem_valid   = 1'b1;
        bus.mem_addr    = 32'h8;
        bus.mem_wdata   = 32'hCAFEF00D;
        bus.mem_wstrb   = 4'hF;
        bus.wait_cycles = 4'd1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.mem_ready && lat < 30);
        check("rst_resp_reached", 32'(bus.mem_ready), 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_resp_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_resp_rdata", bus.mem_rdata, 32'h0);
        check("rst_resp_busy", 32'(bus.busy), 32'd0);
        check("rst_resp_proto", 32'(bus.proto_err), 32'd0);
        check("rst_resp_oob", 32'(bus.oob_err), 32'd0);
        resetn = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        model_oob = 1'b0;
        do_txn(32'h8, 32'h0, 4'h0, 4'd0, rd, lat);
        check("rst_write_dropped", rd, 32'h0);

        // Random traffic against the byte model.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(0, 63));
            else a = 32'($urandom_range(0, 15)) << 2;
            wd = $urandom;
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wt = 4'($urandom_range(0, 15));
            exp_lat = ((wt > 4) ? 4 : int'(wt)) + 1;
            do_txn(a, wd, ws, wt, rd, lat);
            model_access(a, wd, ws, exp_rd);
            check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(exp_lat));
            if (ws == 4'h0) check($sformatf("rnd%0d_rdata@%08h", t, a), rd, exp_rd);
            check($sformatf("rnd%0d_oob", t), 32'(bus.oob_err), 32'(model_oob));
            check($sformatf("rnd%0d_proto", t), 32'(bus.proto_err), 32'd0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
